// File: rtl/grover_pkg.sv
// Shared constants and FSM encoding for the Grover core and its readout block.
`timescale 1ns/1ps
package grover_pkg;

    localparam int N_STATES = 8;
    localparam int AMP_W    = 8;
    localparam int PROB_W   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/amp_square.sv
// Combinational square of a signed amplitude; the result is always non-negative.
`timescale 1ns/1ps
module amp_square
    import grover_pkg::*;
#(
    parameter int AMP_W  = grover_pkg::AMP_W,
    parameter int PROB_W = grover_pkg::PROB_W
) (
    input  logic signed [AMP_W-1:0]  amp_i,
    output logic        [PROB_W-1:0] sq_o
);

    // Full-width signed product; -128*-128 = 16384 still fits the unsigned result.
    logic signed [2*AMP_W-1:0] prod;

    assign prod = amp_i * amp_i;
    assign sq_o = PROB_W'($unsigned(prod));

endmodule

// File: rtl/grover_readout.sv
// Measurement readout: on a rising done, snapshot the amplitudes, scan them one
// per clock for the largest square, and present the winner for one-cycle pulse.
`timescale 1ns/1ps
module grover_readout
    import grover_pkg::*;
#(
    parameter int N_STATES = grover_pkg::N_STATES,
    parameter int AMP_W    = grover_pkg::AMP_W,
    localparam int IDX_W   = $clog2(N_STATES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                done,
    input  logic [IDX_W-1:0]    target_search,
    input  logic [AMP_W-1:0]    o0,
    input  logic [AMP_W-1:0]    o1,
    input  logic [AMP_W-1:0]    o2,
    input  logic [AMP_W-1:0]    o3,
    input  logic [AMP_W-1:0]    o4,
    input  logic [AMP_W-1:0]    o5,
    input  logic [AMP_W-1:0]    o6,
    input  logic [AMP_W-1:0]    o7,
    output logic                busy,
    output logic                meas_valid,
    output logic [IDX_W-1:0]    meas_idx,
    output logic [PROB_W-1:0]   meas_prob,
    output logic                hit,
    output logic [N_STATES-1:0] led
);

    state_e                         state_q;
    logic                           done_q;
    logic                           armed_q;
    logic                           start;
    logic [N_STATES-1:0][AMP_W-1:0] amp_in;
    logic [N_STATES-1:0][AMP_W-1:0] amp_q;
    logic [IDX_W-1:0]               tgt_q;
    logic [IDX_W-1:0]               cnt_q;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [PROB_W-1:0]              max_q, max_d;
    logic [PROB_W-1:0]              sq;
    logic [AMP_W-1:0]               cur_amp;
    logic [N_STATES-1:0]            led_d;

    assign amp_in = {o7, o6, o5, o4, o3, o2, o1, o0};

    // armed_q blocks a done level that was already high when reset released.
    assign start   = done & ~done_q & armed_q;
    assign cur_amp = amp_q[cnt_q];
    assign led_d   = N_STATES'(1) << idx_q;

    amp_square #(
        .AMP_W  (AMP_W),
        .PROB_W (PROB_W)
    ) u_sq (
        .amp_i (cur_amp),
        .sq_o  (sq)
    );

    // Strict compare: on a tie the earlier (lower) index keeps the lead.
    always_comb begin
        max_d = max_q;
        idx_d = idx_q;
        if (sq > max_q) begin
            max_d = sq;
            idx_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            armed_q    <= 1'b0;
            amp_q      <= '0;
            tgt_q      <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            max_q      <= '0;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            meas_idx   <= '0;
            meas_prob  <= '0;
            hit        <= 1'b0;
            led        <= '0;
        end else begin
            done_q     <= done;
            meas_valid <= 1'b0;
            if (!done) armed_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        amp_q   <= amp_in;
                        tgt_q   <= target_search;
                        max_q   <= '0;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    max_q <= max_d;
                    idx_q <= idx_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(N_STATES - 1)) state_q <= REPORT;
                end
                REPORT: begin
                    meas_idx   <= idx_q;
                    meas_prob  <= max_q;
                    hit        <= (idx_q == tgt_q);
                    led        <= led_d;
                    meas_valid <= 1'b1;
                    busy       <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
